fc_argmax: RTL and testbench
============================

# fc_argmax

Classifier output stage that consumes the packed score vector produced by the fully-connected PE array. It selects the largest IEEE-754 single-precision score and returns its index and value. Capture is a single-cycle valid/ready handshake; the scan is sequential, one element per cycle, so no wide comparator tree is built. It sits directly downstream of the FC layer and its result is the network's final class decision.

## Interface
- DATA_WIDTH, 32: score width; IEEE-754 binary32 only.
- NUM_CLASSES, 32: number of scores per vector; equals the FC layer's PE count; legal range 1..256.
- INDEX_WIDTH, 5: width of out_index; must satisfy 2^INDEX_WIDTH >= NUM_CLASSES.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  scores holds a complete vector.
- in_ready  output  1  high only in IDLE; reset value 1.
- scores  input  DATA_WIDTH*NUM_CLASSES  packed vector; element k is scores[DATA_WIDTH*k +: DATA_WIDTH].
- out_valid  output  1  result is held stable; reset value 0.
- out_ready  input  1  consumer accepts the result.
- out_index  output  INDEX_WIDTH  index of the winning element; reset value 0.
- out_score  output  DATA_WIDTH  winning element's raw bits; reset value 0.
- out_nan  output  1  see Configuration; reset value 0; tied to 0 when the feature is compiled out.

## Operation
- States: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register the whole vector into an internal buffer; the upstream may change scores afterwards.
  - Initialise best=element 0, best_idx=0, scan counter k=1.
  - Next state is SCAN, or DONE directly when NUM_CLASSES==1.
- SCAN:
  - Each cycle, compare buffered element k against best.
  - Replace best/best_idx only if element k is strictly greater.
  - Ties keep the lower index.
  - Increment k. After comparing element NUM_CLASSES-1, go to DONE.
- DONE:
  - out_valid=1; out_index and out_score are stable.
  - Stay until out_ready=1, then go to IDLE. out_valid drops on that same edge.
  - in_ready stays 0 throughout DONE; a new vector cannot be accepted in the handshake cycle.
- Ordering uses a total-order key: key = x[31] ? ~x : x ^ 32'h8000_0000, compared as unsigned.
  - -0 orders below +0.
  - -inf is the lowest value and +inf the highest non-NaN value.
  - Subnormals order naturally.
- out_index and out_score are registered; they update only on entry to DONE and hold otherwise.
- Reset asserted mid-SCAN or in DONE:
  - Immediately return to IDLE; the partial result is discarded.
  - Outputs go to their reset values.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored.

## Timing
- Acceptance edge E0 is the first edge with in_valid&&in_ready.
- out_valid is high starting just after edge E(NUM_CLASSES-1). For N=32 that is 31 cycles after E0; for N=1 it is immediately after E0.
- Minimum initiation interval is NUM_CLASSES+1 cycles when out_ready is held high: N-1 scan cycles, 1 DONE cycle, and 1 IDLE cycle.
- Compare-and-update is single-cycle: one key conversion per operand plus one unsigned compare. No pipelining inside SCAN.

## Configuration
- FC_ARGMAX_NAN_SKIP_EN, defined:
  - Any element with exponent all-ones and nonzero mantissa is never selected.
  - If every element is NaN, the result is index 0 with element 0's bits, and out_nan=1 in DONE.
  - out_nan=0 in every other case.
- FC_ARGMAX_NAN_SKIP_EN, undefined:
  - NaNs are ordered by the raw key. A positive NaN beats +inf; a negative NaN loses to -inf.
  - out_nan is constant 0.

## Test plan
- Reset: hold rst_n=0 -> in_ready=1, out_valid=0, out_index=0, out_score=0.
- Basic, N=32: scores[k]=float(k), with element 17 = 100.0 (0x42C8_0000) -> out_index=17, out_score=0x42C8_0000, out_valid rises 31 cycles after E0.
- Tie and negatives: all scores are -1.0 except elements 4 and 9, both 2.5 -> out_index=4. Separately, element 0 = -0.0 and all others +0.0 -> out_index=1.
- Backpressure and async reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
  - Pulse rst_n low mid-SCAN at k=12 -> IDLE next, out_valid=0, the next vector is processed correctly.
- NaN handling:
  - Element 3 = 0x7FC0_0000, element 20 = +inf, rest 1.0. With FC_ARGMAX_NAN_SKIP_EN -> index 20. Without -> index 3.
  - All elements NaN with the macro defined -> index 0, out_nan=1.
- Back-to-back vectors with out_ready tied high -> consecutive acceptances exactly NUM_CLASSES+1 cycles apart, and each result matches its own vector.

Source files
------------

// File: rtl/fc_argmax.sv
// Sequential argmax over a captured vector of binary32 scores, one element per cycle.
// Optional build macro FC_ARGMAX_NAN_SKIP_EN excludes NaN elements from selection.
module fc_argmax #(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_CLASSES = 32,
   parameter int INDEX_WIDTH = 5
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH*NUM_CLASSES-1:0] scores,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [INDEX_WIDTH-1:0]            out_index,
   output logic [DATA_WIDTH-1:0]             out_score,
   output logic                              out_nan
);

   localparam int CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         k_q, k_d;
   logic [DATA_WIDTH-1:0]    best_q, best_d;
   logic [INDEX_WIDTH-1:0]   best_idx_q, best_idx_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic [INDEX_WIDTH-1:0]   out_index_q, out_index_d;
   logic [DATA_WIDTH-1:0]    out_score_q, out_score_d;
   logic [DATA_WIDTH-1:0]    buf_q [NUM_CLASSES];
   logic [DATA_WIDTH-1:0]    cand;
   logic                     take;

   // Map IEEE bits onto an unsigned total order: negatives inverted, positives above them.
   function automatic logic [DATA_WIDTH-1:0] ord_key(input logic [DATA_WIDTH-1:0] x);
      return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
   endfunction

`ifdef FC_ARGMAX_NAN_SKIP_EN
   logic best_nan_q, best_nan_d;
   logic out_nan_q, out_nan_d;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
      return ((x & DATA_WIDTH'(32'h7F80_0000)) == DATA_WIDTH'(32'h7F80_0000)) &&
             ((x & DATA_WIDTH'(32'h007F_FFFF)) != '0);
   endfunction

   // A NaN best yields to any non-NaN candidate.
   assign take = !is_nan(cand) && (best_nan_q || (ord_key(cand) > ord_key(best_q)));
   assign out_nan = out_nan_q;
`else
   assign take = ord_key(cand) > ord_key(best_q);
   assign out_nan = 1'b0;
`endif

   assign cand      = buf_q[k_q];
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_score = out_score_q;

   always_ff @(posedge clk) begin
      if (in_valid && in_ready_q) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            buf_q[i] <= scores[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      out_score_d = out_score_q;
`ifdef FC_ARGMAX_NAN_SKIP_EN
      best_nan_d  = best_nan_q;
      out_nan_d   = out_nan_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               best_d     = scores[DATA_WIDTH-1:0];
               best_idx_d = '0;
               k_d        = CNT_W'(1);
               in_ready_d = 1'b0;
`ifdef FC_ARGMAX_NAN_SKIP_EN
               best_nan_d = is_nan(scores[DATA_WIDTH-1:0]);
`endif
               if (NUM_CLASSES == 1) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  out_index_d = '0;
                  out_score_d = scores[DATA_WIDTH-1:0];
`ifdef FC_ARGMAX_NAN_SKIP_EN
                  out_nan_d   = best_nan_d;
`endif
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (take) begin
               best_d     = cand;
               best_idx_d = INDEX_WIDTH'(k_q);
`ifdef FC_ARGMAX_NAN_SKIP_EN
               best_nan_d = 1'b0;
`endif
            end
            k_d = k_q + 1'b1;
            // Final compare folds straight into the output registers.
            if (k_q == LAST_K) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_index_d = best_idx_d;
               out_score_d = best_d;
`ifdef FC_ARGMAX_NAN_SKIP_EN
               out_nan_d   = best_nan_d;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_score_q <= '0;
`ifdef FC_ARGMAX_NAN_SKIP_EN
         best_nan_q  <= 1'b0;
         out_nan_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_score_q <= out_score_d;
`ifdef FC_ARGMAX_NAN_SKIP_EN
         best_nan_q  <= best_nan_d;
         out_nan_q   <= out_nan_d;
`endif
      end
   end

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax (N=32): reset, ordering, ties, backpressure, reset abort, NaN, throughput.
module tb_fc_argmax;

   localparam int N  = 32;
   localparam int DW = 32;
   localparam int IW = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [DW*N-1:0] scores = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [IW-1:0]   out_index;
   logic [DW-1:0]   out_score;
   logic            out_nan;

   int total = 0;
   int bad   = 0;
   logic [31:0] vec [N];

   fc_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(N), .INDEX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .scores(scores), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_score(out_score), .out_nan(out_nan)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] int_to_float(input int k);
      int e;
      logic [31:0] m;
      if (k == 0) return 32'h0;
      e = 0;
      while ((k >> (e + 1)) != 0) e++;
      m = (32'(k) << (23 - e)) & 32'h007F_FFFF;
      return (32'(127 + e) << 23) | m;
   endfunction

   function automatic logic [DW*N-1:0] pack_vec();
      logic [DW*N-1:0] p;
      for (int i = 0; i < N; i++) p[DW*i +: DW] = vec[i];
      return p;
   endfunction

   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < N; i++) vec[i] = v;
   endtask

   // Present vec for one acceptance edge, scramble the bus, count edges until out_valid.
   task automatic send_and_wait(output int lat, output bit timeout);
      @(negedge clk);
      scores   = pack_vec();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scores   = {N{32'h7F7F_FFFF}};
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      timeout = (lat >= 100);
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== '0 || out_score !== '0 || out_nan !== 1'b0) begin
         bad++;
         $display("FAIL reset: in_ready=%b out_valid=%b idx=%0d score=%h nan=%b, required 1 0 0 0 0",
                  in_ready, out_valid, out_index, out_score, out_nan);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat; bit to;
      for (int i = 0; i < N; i++) vec[i] = int_to_float(i);
      vec[17] = 32'h42C8_0000;
      send_and_wait(lat, to);
      total++;
      if (to || lat !== N - 1) begin
         bad++;
         $display("FAIL basic_latency: got %0d timeout=%b, required %0d", lat, to, N - 1);
      end
      total++;
      if (out_index !== 5'd17 || out_score !== 32'h42C8_0000) begin
         bad++;
         $display("FAIL basic_result: idx=%0d score=%h, required 17 42c80000", out_index, out_score);
      end
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_tie_neg();
      int lat; bit to;
      fill(32'hBF80_0000);
      vec[4] = 32'h4020_0000;
      vec[9] = 32'h4020_0000;
      send_and_wait(lat, to);
      total++;
      if (to || out_index !== 5'd4 || out_score !== 32'h4020_0000) begin
         bad++;
         $display("FAIL tie: idx=%0d score=%h timeout=%b, required 4 40200000", out_index, out_score, to);
      end
      release_result();
      fill(32'h0000_0000);
      vec[0] = 32'h8000_0000;
      send_and_wait(lat, to);
      total++;
      if (to || out_index !== 5'd1 || out_score !== 32'h0000_0000) begin
         bad++;
         $display("FAIL signed_zero: idx=%0d score=%h, required 1 00000000", out_index, out_score);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat; bit to;
      fill(32'hC000_0000);
      vec[31] = 32'hBF00_0000;
      send_and_wait(lat, to);
      total++;
      if (to) begin
         bad++;
         $display("FAIL bp_timeout: got %0d cycles, required %0d", lat, N - 1);
      end
      // A competing vector offered during DONE must be ignored.
      @(negedge clk);
      fill(32'h4000_0000);
      scores   = pack_vec();
      in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== 5'd31 || out_score !== 32'hBF00_0000) begin
            bad++;
            $display("FAIL bp_hold%0d: valid=%b ready=%b idx=%0d score=%h, required 1 0 31 bf000000",
                     c, out_valid, in_ready, out_index, out_score);
         end
      end
      in_valid = 1'b0;
      release_result();
   endtask

   task automatic test_async_reset();
      int lat; bit to;
      fill(32'h3F80_0000);
      vec[25] = 32'h4080_0000;
      @(negedge clk);
      scores   = pack_vec();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== '0 || out_score !== '0) begin
         bad++;
         $display("FAIL mid_scan_reset: ready=%b valid=%b idx=%0d score=%h, required 1 0 0 0",
                  in_ready, out_valid, out_index, out_score);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_stays_idle: out_valid=%b, required 0", out_valid);
      end
      vec[25] = 32'h3F80_0000;
      vec[7]  = 32'h4100_0000;
      send_and_wait(lat, to);
      total++;
      if (to || lat !== N - 1 || out_index !== 5'd7 || out_score !== 32'h4100_0000) begin
         bad++;
         $display("FAIL after_reset: idx=%0d score=%h lat=%0d, required 7 41000000 %0d",
                  out_index, out_score, lat, N - 1);
      end
      release_result();
   endtask

   task automatic test_nan();
      int lat; bit to;
      logic [IW-1:0] exp_idx;
      logic [31:0]   exp_score;
      logic          exp_nan;
`ifdef FC_ARGMAX_NAN_SKIP_EN
      exp_idx = 5'd20; exp_score = 32'h7F80_0000; exp_nan = 1'b1;
`else
      exp_idx = 5'd3;  exp_score = 32'h7FC0_0000; exp_nan = 1'b0;
`endif
      fill(32'h3F80_0000);
      vec[3]  = 32'h7FC0_0000;
      vec[20] = 32'h7F80_0000;
      send_and_wait(lat, to);
      total++;
      if (to || out_index !== exp_idx || out_score !== exp_score || out_nan !== 1'b0) begin
         bad++;
         $display("FAIL nan_mix: idx=%0d score=%h nan=%b, required %0d %h 0",
                  out_index, out_score, out_nan, exp_idx, exp_score);
      end
      release_result();
      fill(32'h7FC0_0000);
      vec[0]  = 32'hFFC0_0001;
      vec[12] = 32'h7F80_0001;
      send_and_wait(lat, to);
`ifdef FC_ARGMAX_NAN_SKIP_EN
      exp_idx = 5'd0; exp_score = 32'hFFC0_0001;
`else
      exp_idx = 5'd1; exp_score = 32'h7FC0_0000;
`endif
      total++;
      if (to || out_index !== exp_idx || out_score !== exp_score || out_nan !== exp_nan) begin
         bad++;
         $display("FAIL all_nan: idx=%0d score=%h nan=%b, required %0d %h %b",
                  out_index, out_score, out_nan, exp_idx, exp_score, exp_nan);
      end
      release_result();
   endtask

   task automatic test_back_to_back();
      int win [3] = '{5, 30, 0};
      time acc [3];
      int polls;
      out_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         fill(32'h3F80_0000);
         vec[win[v]] = 32'h4000_0000;
         scores   = pack_vec();
         in_valid = 1'b1;
         @(posedge clk);
         acc[v] = $time;
         polls = 0;
         @(negedge clk);
         while (!out_valid && polls < 100) begin
            @(negedge clk);
            polls++;
         end
         total++;
         if (polls >= 100 || out_index !== IW'(win[v]) || out_score !== 32'h4000_0000) begin
            bad++;
            $display("FAIL b2b_result%0d: idx=%0d score=%h, required %0d 40000000",
                     v, out_index, out_score, win[v]);
         end
         @(negedge clk);
         if (v > 0) begin
            total++;
            if ((acc[v] - acc[v-1]) / 10 != N + 1) begin
               bad++;
               $display("FAIL b2b_interval%0d: got %0d cycles, required %0d",
                        v, (acc[v] - acc[v-1]) / 10, N + 1);
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie_neg();
      test_backpressure();
      test_async_reset();
      test_nan();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
